// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for a single I2C master engine.
// It latches the winning command, runs the start/busy/done handshake, returns status and aborts stalled transfers.
module i2c_req_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rw,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_done,
  output logic [7:0] req0_rdata,
  output logic       req0_nack,
  input  logic       req1_valid,
  input  logic       req1_rw,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_done,
  output logic [7:0] req1_rdata,
  output logic       req1_nack,
  output logic       m_start,
  output logic       m_rw,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_ack,
  input  logic [7:0] m_rdata,
  output logic       err_timeout
);

  localparam logic [15:0] LP_LAST_CNT = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_last;
  logic [15:0]     r_cnt;
  logic            r_start;
  logic            r_rw;
  logic [6:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [1:0]      r_ready;
  logic [1:0]      r_done;
  logic [1:0][7:0] r_rdata;
  logic [1:0]      r_nack;
  logic            r_err;

  logic w_any;
  logic w_grant1;
  logic w_timeout;

  assign w_any     = req0_valid | req1_valid;
  // On a tie the requester that did not win last time gets the grant.
  assign w_grant1  = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_timeout = (r_cnt == LP_LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_nack  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner           <= w_grant1;
            r_last            <= w_grant1;
            r_rw              <= w_grant1 ? req1_rw    : req0_rw;
            r_addr            <= w_grant1 ? req1_addr  : req0_addr;
            r_wdata           <= w_grant1 ? req1_wdata : req0_wdata;
            r_ready[w_grant1] <= 1'b1;
            r_start           <= 1'b1;
            r_cnt             <= '0;
            r_state           <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT_DONE: begin
          r_cnt <= r_cnt + 16'd1;
          // A completion arriving on the last allowed cycle beats the abort.
          if (m_done) begin
            r_done[r_owner]  <= 1'b1;
            r_nack[r_owner]  <= ~m_ack;
            r_rdata[r_owner] <= r_rw ? m_rdata : 8'h00;
            r_start          <= 1'b0;
            r_state          <= S_RESP;
          end else if (w_timeout) begin
            r_done[r_owner]  <= 1'b1;
            r_nack[r_owner]  <= 1'b1;
            r_rdata[r_owner] <= 8'h00;
            r_err            <= 1'b1;
            r_start          <= 1'b0;
            r_state          <= S_RESP;
          end else if ((r_state == S_ISSUE) && m_busy) begin
            r_start <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = r_ready[0];
  assign req1_ready  = r_ready[1];
  assign req0_done   = r_done[0];
  assign req1_done   = r_done[1];
  assign req0_rdata  = r_rdata[0];
  assign req1_rdata  = r_rdata[1];
  assign req0_nack   = r_nack[0];
  assign req1_nack   = r_nack[1];
  assign m_start     = r_start;
  assign m_rw        = r_rw;
  assign m_addr      = r_addr;
  assign m_wdata     = r_wdata;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed handshake scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_i2c_req_arbiter;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req0_rw, req0_ready, req0_done, req0_nack;
  logic [6:0] req0_addr;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_rw, req1_ready, req1_done, req1_nack;
  logic [6:0] req1_addr;
  logic [7:0] req1_wdata, req1_rdata;
  logic       m_start, m_rw, m_busy, m_done, m_ack, err_timeout;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rdata;

  int checks   = 0;
  int failures = 0;

  i2c_req_arbiter #(.TIMEOUT_CYCLES(16'(TO))) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_nack(req0_nack),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_nack(req1_nack),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_ack(m_ack), .m_rdata(m_rdata),
    .err_timeout(err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the transaction in flight (owner, age since issue,
  // whether the engine has reported busy) and what each requester must see next cycle.
  bit          model_on = 1'b0;
  int          own      = -1;
  bit          in_resp  = 1'b0;
  bit          engaged  = 1'b0;
  bit          last_win = 1'b1;
  int unsigned age      = 0;
  logic        e_ready [2];
  logic        e_done  [2];
  logic        e_nack  [2];
  logic [7:0]  e_rdata [2];
  logic        e_start, e_rw, e_err;
  logic [6:0]  e_addr;
  logic [7:0]  e_wdata;

  task automatic conclude(input logic nack, input logic [7:0] rd, input logic err);
    e_done[own]  = 1'b1;
    e_nack[own]  = nack;
    e_rdata[own] = rd;
    e_err        = err;
    e_start      = 1'b0;
    in_resp      = 1'b1;
  endtask

  task automatic model_step();
    int who;
    for (int i = 0; i < 2; i++) begin
      e_ready[i] = 1'b0;
      e_done[i]  = 1'b0;
    end
    e_err = 1'b0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        e_nack[i]  = 1'b0;
        e_rdata[i] = 8'h00;
      end
      e_start = 1'b0; e_rw = 1'b0; e_addr = '0; e_wdata = '0;
      own = -1; in_resp = 1'b0; last_win = 1'b1;
    end else if (in_resp) begin
      in_resp = 1'b0;
      own     = -1;
    end else if (own >= 0) begin
      if (m_done)
        conclude(!m_ack, e_rw ? m_rdata : 8'h00, 1'b0);
      else if (age == TO - 1)
        conclude(1'b1, 8'h00, 1'b1);
      else begin
        age++;
        if (m_busy) engaged = 1'b1;
        e_start = !engaged;
      end
    end else if (req0_valid || req1_valid) begin
      if (req0_valid && req1_valid) who = last_win ? 0 : 1;
      else                          who = req1_valid ? 1 : 0;
      last_win     = (who == 1);
      own          = who;
      age          = 0;
      engaged      = 1'b0;
      e_start      = 1'b1;
      e_ready[who] = 1'b1;
      e_rw         = who ? req1_rw    : req0_rw;
      e_addr       = who ? req1_addr  : req0_addr;
      e_wdata      = who ? req1_wdata : req0_wdata;
    end
    model_on = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      check("req0_ready",  req0_ready,  e_ready[0]);
      check("req1_ready",  req1_ready,  e_ready[1]);
      check("req0_done",   req0_done,   e_done[0]);
      check("req1_done",   req1_done,   e_done[1]);
      check("req0_nack",   req0_nack,   e_nack[0]);
      check("req1_nack",   req1_nack,   e_nack[1]);
      check("req0_rdata",  req0_rdata,  e_rdata[0]);
      check("req1_rdata",  req1_rdata,  e_rdata[1]);
      check("m_start",     m_start,     e_start);
      check("m_rw",        m_rw,        e_rw);
      check("m_addr",      m_addr,      e_addr);
      check("m_wdata",     m_wdata,     e_wdata);
      check("err_timeout", err_timeout, e_err);
    end
  end

  function automatic logic done_of(input int who);
    return who ? req1_done : req0_done;
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_ack = 1'b0; m_rdata = 8'h00;
  endtask

  task automatic post(input int who, input logic rw, input logic [6:0] a, input logic [7:0] d);
    if (who == 0) begin
      req0_valid = 1'b1; req0_rw = rw; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_rw = rw; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic wait_start(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      waited++;
      if (m_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL m_start_wait: got no m_start, want m_start within 12 cycles at %0t", $time);
    end
  endtask

  // Plays the engine from the first issue cycle (n=0); ddly < 0 never completes.
  task automatic serve(input int bdly, input int ddly, input logic ack, input logic [7:0] rd,
                       input int who, input logic rw);
    int last_n;
    last_n = (ddly < 0) ? int'(TO) : ddly + 1;
    for (int n = 0; n <= last_n; n++) begin
      if (n > 0) @(negedge clk);
      if (n == last_n) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        check("resp done owner", done_of(who), 1'b1);
        check("resp done other", done_of(1 - who), 1'b0);
        check("resp err", err_timeout, (ddly < 0));
        check("resp nack", who ? req1_nack : req0_nack, (ddly < 0) ? 1'b1 : !ack);
        check("resp rdata", who ? req1_rdata : req0_rdata, (ddly < 0 || !rw) ? 8'h00 : rd);
        check("model done", e_done[who], 1'b1);
      end else begin
        if (n > 0) check("done not early", done_of(who), 1'b0);
        m_busy  = (n >= bdly);
        m_done  = (n == ddly);
        m_ack   = ack;
        m_rdata = rd;
      end
    end
  endtask

  task automatic txn(input int who, input logic rw, input logic [6:0] a, input logic [7:0] d,
                     input int bdly, input int ddly, input logic ack, input logic [7:0] rd);
    bit ok;
    int waited;
    @(negedge clk);
    post(who, rw, a, d);
    wait_start(ok, waited);
    if (ok) begin
      check("ready latency", waited, 1);
      check("ready owner", who ? req1_ready : req0_ready, 1'b1);
      check("ready other", who ? req0_ready : req1_ready, 1'b0);
      check("latched addr", m_addr, a);
      check("latched wdata", m_wdata, d);
      check("latched rw", m_rw, rw);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      serve(bdly, ddly, ack, rd, who, rw);
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish before 1 ms");
    $fatal(1);
  end

  initial begin
    bit ok;
    int waited;
    rst = 1'b1;
    req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset m_start", m_start, 1'b0);
    check("reset done", {req0_done, req1_done}, 2'b00);
    check("reset ready", {req0_ready, req1_ready}, 2'b00);
    check("reset m_addr", m_addr, 7'h00);
    check("reset err", err_timeout, 1'b0);
    check("model reset start", e_start, 1'b0);
    rst = 1'b0;

    txn(0, 1'b0, 7'h50, 8'hA5, 2, 13, 1'b1, 8'hFF);
    txn(0, 1'b0, 7'h51, 8'h5A, 1, 4, 1'b0, 8'h00);
    txn(1, 1'b1, 7'h3C, 8'h00, 1, 6, 1'b1, 8'h7E);
    check("req0 nack held", req0_nack, 1'b1);
    check("req0 rdata held", req0_rdata, 8'h00);
    check("req1 rdata held", req1_rdata, 8'h7E);
    txn(0, 1'b0, 7'h52, 8'h01, 1, 3, 1'b1, 8'h00);
    txn(1, 1'b1, 7'h10, 8'h00, 99, 0, 1'b1, 8'h99);
    txn(0, 1'b1, 7'h15, 8'h00, 2, 15, 1'b1, 8'hC3);
    txn(0, 1'b0, 7'h2A, 8'h33, 0, -1, 1'b1, 8'hEE);
    txn(1, 1'b0, 7'h2B, 8'h44, 1, 2, 1'b1, 8'h00);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    post(0, 1'b0, 7'h11, 8'h01);
    post(1, 1'b1, 7'h22, 8'h02);
    for (int g = 0; g < 4; g++) begin
      wait_start(ok, waited);
      if (!ok) break;
      check("rr req0_ready", req0_ready, (g % 2 == 0));
      check("rr req1_ready", req1_ready, (g % 2 == 1));
      check("rr m_addr", m_addr, (g % 2 == 1) ? 7'h22 : 7'h11);
      serve(1, 3, 1'b1, 8'(8'h40 + g), g % 2, (g % 2 == 1));
    end
    idle_inputs();

    @(negedge clk);
    post(0, 1'b0, 7'h60, 8'h12);
    wait_start(ok, waited);
    req0_valid = 1'b0;
    m_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_busy = 1'b0;
    check("mid-rst m_start", m_start, 1'b0);
    check("mid-rst done", {req0_done, req1_done}, 2'b00);
    check("mid-rst m_addr", m_addr, 7'h00);
    post(0, 1'b0, 7'h61, 8'h13);
    post(1, 1'b0, 7'h62, 8'h14);
    wait_start(ok, waited);
    check("post-rst tie winner", {req1_ready, req0_ready}, 2'b01);
    check("model tie winner", e_ready[0], 1'b1);
    idle_inputs();
    repeat (4) @(negedge clk);
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 299) == 0);
      req0_valid = ($urandom_range(0, 2) == 0);
      req0_rw    = 1'($urandom);
      req0_addr  = 7'($urandom);
      req0_wdata = 8'($urandom);
      req1_valid = ($urandom_range(0, 2) == 0);
      req1_rw    = 1'($urandom);
      req1_addr  = 7'($urandom);
      req1_wdata = 8'($urandom);
      m_busy     = 1'($urandom);
      m_done     = ($urandom_range(0, 5) == 0);
      m_ack      = 1'($urandom);
      m_rdata    = 8'($urandom);
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
